// File: rtl/cache_pkg.sv
// Shared types and geometry helpers for the 2-way write-back data cache.
package cache_pkg;

   typedef enum logic [1:0] {IDLE, WB, RF_REQ, RF_WAIT} state_t;

   function automatic int off_w(input int line_words);
      return $clog2(line_words) + 2;
   endfunction

   function automatic int idx_w(input int sets);
      return $clog2(sets);
   endfunction

   function automatic int tag_w(input int addr_w, input int sets, input int line_words);
      return addr_w - idx_w(sets) - off_w(line_words);
   endfunction

endpackage

// File: rtl/cache_way_array.sv
// One cache way: tag/line storage with async read, posedge writes; valid/dirty cleared by async reset.
module cache_way_array #(
   parameter int SETS       = 32,
   parameter int IDX_W      = 5,
   parameter int TAG_W      = 23,
   parameter int LINE_WORDS = 4
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic [IDX_W-1:0]               idx,
   output logic                           rd_valid,
   output logic                           rd_dirty,
   output logic [TAG_W-1:0]               rd_tag,
   output logic [32*LINE_WORDS-1:0]       rd_line,
   input  logic                           word_we,
   input  logic [$clog2(LINE_WORDS)-1:0]  word_sel,
   input  logic [31:0]                    word_dat,
   input  logic                           fill_we,
   input  logic [TAG_W-1:0]               fill_tag,
   input  logic [32*LINE_WORDS-1:0]       fill_line,
   input  logic                           clean_we
);

   logic [SETS-1:0]             valid_q;
   logic [SETS-1:0]             dirty_q;
   logic [TAG_W-1:0]            tag_q  [SETS];
   logic [32*LINE_WORDS-1:0]    line_q [SETS];

   assign rd_valid = valid_q[idx];
   assign rd_dirty = dirty_q[idx];
   assign rd_tag   = tag_q[idx];
   assign rd_line  = line_q[idx];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         valid_q <= '0;
         dirty_q <= '0;
      end else if (fill_we) begin
         valid_q[idx] <= 1'b1;
         dirty_q[idx] <= 1'b0;
      end else if (word_we) begin
         dirty_q[idx] <= 1'b1;
      end else if (clean_we) begin
         dirty_q[idx] <= 1'b0;
      end
   end

   // Payload storage is deliberately not reset; valid bits gate every use of it.
   always_ff @(posedge clk) begin
      if (fill_we) begin
         tag_q[idx]  <= fill_tag;
         line_q[idx] <= fill_line;
      end else if (word_we) begin
         line_q[idx][32*int'(word_sel) +: 32] <= word_dat;
      end
   end

endmodule

// File: rtl/assoc_cache_wb.sv
// 2-way set-associative write-back/write-allocate cache; hits complete in 0 cycles,
// misses stall the core through victim writeback and refill, each held until mem_req_ready.
module assoc_cache_wb
   import cache_pkg::*;
#(
   parameter int ADDR_W     = 32,
   parameter int SETS       = 32,
   parameter int LINE_WORDS = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       cpu_req_valid,
   input  logic                       cpu_req_we,
   input  logic [ADDR_W-1:0]          cpu_req_addr,
   input  logic [31:0]                cpu_req_wdata,
   output logic                       cpu_resp_valid,
   output logic [31:0]                cpu_resp_rdata,
   output logic                       cpu_stall,
   output logic                       mem_req_valid,
   output logic                       mem_req_we,
   output logic [ADDR_W-1:0]          mem_req_addr,
   output logic [32*LINE_WORDS-1:0]   mem_req_wdata,
   input  logic                       mem_req_ready,
   input  logic                       mem_resp_valid,
   input  logic [32*LINE_WORDS-1:0]   mem_resp_rdata
);

   localparam int OFF_W  = off_w(LINE_WORDS);
   localparam int IDX_W  = idx_w(SETS);
   localparam int TAG_W  = tag_w(ADDR_W, SETS, LINE_WORDS);
   localparam int LINE_W = 32 * LINE_WORDS;
   localparam int WSEL_W = $clog2(LINE_WORDS);

   state_t              state;
   logic [SETS-1:0]     lru_q;
   logic                victim_q;
   logic [TAG_W-1:0]    miss_tag;
   logic [IDX_W-1:0]    miss_idx;

   logic [TAG_W-1:0]    req_tag;
   logic [IDX_W-1:0]    req_idx;
   logic [WSEL_W-1:0]   req_wsel;
   logic [IDX_W-1:0]    arr_idx;
   logic                unused_addr_bits;

   assign req_tag          = cpu_req_addr[ADDR_W-1 -: TAG_W];
   assign req_idx          = cpu_req_addr[OFF_W +: IDX_W];
   assign req_wsel         = cpu_req_addr[2 +: WSEL_W];
   assign unused_addr_bits = ^cpu_req_addr[1:0];
   // The miss set is latched so the arrays stay pointed at it for the whole transfer.
   assign arr_idx          = (state == IDLE) ? req_idx : miss_idx;

   logic [1:0]          rd_valid;
   logic [1:0]          rd_dirty;
   logic [TAG_W-1:0]    rd_tag  [2];
   logic [LINE_W-1:0]   rd_line [2];
   logic [1:0]          word_we;
   logic [1:0]          fill_we;
   logic [1:0]          clean_we;

   for (genvar w = 0; w < 2; w++) begin : g_way
      cache_way_array #(
         .SETS       (SETS),
         .IDX_W      (IDX_W),
         .TAG_W      (TAG_W),
         .LINE_WORDS (LINE_WORDS)
      ) u_way (
         .clk       (clk),
         .rst       (rst),
         .idx       (arr_idx),
         .rd_valid  (rd_valid[w]),
         .rd_dirty  (rd_dirty[w]),
         .rd_tag    (rd_tag[w]),
         .rd_line   (rd_line[w]),
         .word_we   (word_we[w]),
         .word_sel  (req_wsel),
         .word_dat  (cpu_req_wdata),
         .fill_we   (fill_we[w]),
         .fill_tag  (miss_tag),
         .fill_line (mem_resp_rdata),
         .clean_we  (clean_we[w])
      );
   end

   logic              hit0;
   logic              hit1;
   logic              hit_any;
   logic              hit_way;
   logic              victim;
   logic [LINE_W-1:0] hit_line;

   assign hit0     = rd_valid[0] && (rd_tag[0] == req_tag);
   assign hit1     = rd_valid[1] && (rd_tag[1] == req_tag);
   assign hit_any  = hit0 || hit1;
   assign hit_way  = !hit0;
   assign hit_line = hit0 ? rd_line[0] : rd_line[1];
   assign victim   = !rd_valid[0] ? 1'b0 : (!rd_valid[1] ? 1'b1 : lru_q[req_idx]);

   // Reset gates the combinational outputs so every port reads 0 while rst is low.
   assign cpu_resp_valid = rst && (state == IDLE) && cpu_req_valid && hit_any;
   assign cpu_stall      = rst && ((state != IDLE) || (cpu_req_valid && !hit_any));
   assign cpu_resp_rdata = (cpu_resp_valid && !cpu_req_we) ?
                           hit_line[32*int'(req_wsel) +: 32] : 32'h0;

   always_comb begin
      word_we  = 2'b00;
      fill_we  = 2'b00;
      clean_we = 2'b00;
      word_we[hit_way]   = cpu_resp_valid && cpu_req_we;
      fill_we[victim_q]  = (state == RF_WAIT) && mem_resp_valid;
      clean_we[victim_q] = (state == WB) && mem_req_ready;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state         <= IDLE;
         lru_q         <= '0;
         victim_q      <= 1'b0;
         miss_tag      <= '0;
         miss_idx      <= '0;
         mem_req_valid <= 1'b0;
         mem_req_we    <= 1'b0;
         mem_req_addr  <= '0;
         mem_req_wdata <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (cpu_req_valid && hit_any) begin
                  lru_q[req_idx] <= ~hit_way;
               end else if (cpu_req_valid) begin
                  victim_q      <= victim;
                  miss_tag      <= req_tag;
                  miss_idx      <= req_idx;
                  mem_req_valid <= 1'b1;
                  if (rd_valid[victim] && rd_dirty[victim]) begin
                     state         <= WB;
                     mem_req_we    <= 1'b1;
                     mem_req_addr  <= {rd_tag[victim], req_idx, {OFF_W{1'b0}}};
                     mem_req_wdata <= rd_line[victim];
                  end else begin
                     state         <= RF_REQ;
                     mem_req_we    <= 1'b0;
                     mem_req_addr  <= {req_tag, req_idx, {OFF_W{1'b0}}};
                  end
               end
            end
            WB: begin
               if (mem_req_ready) begin
                  state        <= RF_REQ;
                  mem_req_we   <= 1'b0;
                  mem_req_addr <= {miss_tag, miss_idx, {OFF_W{1'b0}}};
               end
            end
            RF_REQ: begin
               if (mem_req_ready) begin
                  state         <= RF_WAIT;
                  mem_req_valid <= 1'b0;
               end
            end
            RF_WAIT: begin
               if (mem_resp_valid) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_assoc_cache_wb.sv
// Directed bench driving two cache geometries (32x4 and 8x8) in lockstep with identical traffic.
module tb_assoc_cache_wb;

   logic         clk = 1'b0;
   logic         rst;
   logic         cpu_req_valid, cpu_req_we;
   logic [31:0]  cpu_req_addr, cpu_req_wdata;
   logic         mem_req_ready, mem_resp_valid;
   logic [255:0] resp_line;

   logic         a_resp_valid, a_stall, a_mem_valid, a_mem_we;
   logic [31:0]  a_rdata, a_mem_addr;
   logic [127:0] a_mem_wdata;
   logic         b_resp_valid, b_stall, b_mem_valid, b_mem_we;
   logic [31:0]  b_rdata, b_mem_addr;
   logic [255:0] b_mem_wdata;

   int checks = 0;
   int passes = 0;

   always #5 clk = ~clk;

   assoc_cache_wb #(.ADDR_W(32), .SETS(32), .LINE_WORDS(4)) dut_a (
      .clk(clk), .rst(rst),
      .cpu_req_valid(cpu_req_valid), .cpu_req_we(cpu_req_we),
      .cpu_req_addr(cpu_req_addr), .cpu_req_wdata(cpu_req_wdata),
      .cpu_resp_valid(a_resp_valid), .cpu_resp_rdata(a_rdata), .cpu_stall(a_stall),
      .mem_req_valid(a_mem_valid), .mem_req_we(a_mem_we), .mem_req_addr(a_mem_addr),
      .mem_req_wdata(a_mem_wdata), .mem_req_ready(mem_req_ready),
      .mem_resp_valid(mem_resp_valid), .mem_resp_rdata(resp_line[127:0])
   );

   assoc_cache_wb #(.ADDR_W(32), .SETS(8), .LINE_WORDS(8)) dut_b (
      .clk(clk), .rst(rst),
      .cpu_req_valid(cpu_req_valid), .cpu_req_we(cpu_req_we),
      .cpu_req_addr(cpu_req_addr), .cpu_req_wdata(cpu_req_wdata),
      .cpu_resp_valid(b_resp_valid), .cpu_resp_rdata(b_rdata), .cpu_stall(b_stall),
      .mem_req_valid(b_mem_valid), .mem_req_we(b_mem_we), .mem_req_addr(b_mem_addr),
      .mem_req_wdata(b_mem_wdata), .mem_req_ready(mem_req_ready),
      .mem_resp_valid(mem_resp_valid), .mem_resp_rdata(resp_line)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) passes++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic c2(input string tag, input logic [63:0] oa, input logic [63:0] ob,
                     input logic [63:0] exp);
      chk({tag, "/a"}, oa, exp);
      chk({tag, "/b"}, ob, exp);
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic set_line(input logic [31:0] base);
      for (int i = 0; i < 8; i++) resp_line[32*i +: 32] = base + i;
   endtask

   task automatic req(input logic we, input logic [31:0] addr, input logic [31:0] wd);
      cpu_req_valid = 1'b1;
      cpu_req_we    = we;
      cpu_req_addr  = addr;
      cpu_req_wdata = wd;
   endtask

   // Entered with a missing clean request freshly driven in IDLE.
   task automatic refill(input string tag, input logic [31:0] line_addr,
                         input logic [31:0] base, input logic [31:0] exp_rd);
      #1;
      c2({tag, " miss stall"}, a_stall, b_stall, 1);
      c2({tag, " miss resp"}, a_resp_valid, b_resp_valid, 0);
      cyc();
      c2({tag, " rf valid"}, a_mem_valid, b_mem_valid, 1);
      c2({tag, " rf we"}, a_mem_we, b_mem_we, 0);
      c2({tag, " rf addr"}, a_mem_addr, b_mem_addr, line_addr);
      mem_req_ready = 1'b1;
      cyc();
      mem_req_ready = 1'b0;
      c2({tag, " wait valid"}, a_mem_valid, b_mem_valid, 0);
      c2({tag, " wait stall"}, a_stall, b_stall, 1);
      set_line(base);
      mem_resp_valid = 1'b1;
      cyc();
      mem_resp_valid = 1'b0;
      c2({tag, " hit resp"}, a_resp_valid, b_resp_valid, 1);
      c2({tag, " hit stall"}, a_stall, b_stall, 0);
      c2({tag, " hit rdata"}, a_rdata, b_rdata, exp_rd);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b0;
      mem_req_ready = 1'b0;
      mem_resp_valid = 1'b0;
      resp_line = '0;
      req(1'b0, 32'h100, 32'h0);
      #2;
      c2("rst resp", a_resp_valid, b_resp_valid, 0);
      c2("rst stall", a_stall, b_stall, 0);
      c2("rst mvalid", a_mem_valid, b_mem_valid, 0);
      c2("rst maddr", a_mem_addr, b_mem_addr, 0);
      c2("rst rdata", a_rdata, b_rdata, 0);
      cyc();
      rst = 1'b1;
      refill("t1", 32'h100, 32'h1, 32'h1);

      // Store hit completes in the same cycle without memory traffic.
      cyc();
      req(1'b1, 32'h104, 32'hDEAD_BEEF);
      #1;
      c2("t2 st resp", a_resp_valid, b_resp_valid, 1);
      c2("t2 st stall", a_stall, b_stall, 0);
      c2("t2 st rdata", a_rdata, b_rdata, 0);
      c2("t2 st mvalid", a_mem_valid, b_mem_valid, 0);
      cyc();
      req(1'b0, 32'h104, 32'h0);
      #1;
      c2("t2 ld 104", a_rdata, b_rdata, 32'hDEAD_BEEF);
      cyc();
      req(1'b0, 32'h108, 32'h0);
      #1;
      c2("t2 ld 108", a_rdata, b_rdata, 32'h3);

      // Fill way 1, touch way 0, then a third tag must evict the clean way 1.
      cyc();
      req(1'b0, 32'h1100, 32'h0);
      refill("t3 1100", 32'h1100, 32'h10, 32'h10);
      cyc();
      req(1'b0, 32'h100, 32'h0);
      #1;
      c2("t3 ld 100", a_rdata, b_rdata, 32'h1);
      cyc();
      req(1'b0, 32'h2100, 32'h0);
      refill("t3 2100", 32'h2100, 32'h20, 32'h20);
      cyc();
      req(1'b0, 32'h100, 32'h0);
      #1;
      c2("t3 100 kept", a_resp_valid, b_resp_valid, 1);
      cyc();
      req(1'b0, 32'h1100, 32'h0);
      #1;
      c2("t3 1100 gone", a_stall, b_stall, 1);

      // Dirty eviction: make way 0 (0x100) the LRU, then miss on a fourth tag.
      req(1'b1, 32'h100, 32'hCAFE_0001);
      #1;
      c2("t4 st resp", a_resp_valid, b_resp_valid, 1);
      cyc();
      req(1'b0, 32'h2100, 32'h0);
      #1;
      c2("t4 ld 2100", a_rdata, b_rdata, 32'h20);
      cyc();
      req(1'b0, 32'h3100, 32'h0);
      #1;
      c2("t4 miss stall", a_stall, b_stall, 1);
      for (int i = 0; i < 5; i++) begin
         cyc();
         c2("t5 wb valid", a_mem_valid, b_mem_valid, 1);
         c2("t5 wb we", a_mem_we, b_mem_we, 1);
         c2("t5 wb addr", a_mem_addr, b_mem_addr, 32'h100);
         c2("t5 wb stall", a_stall, b_stall, 1);
      end
      c2("t4 wb data", a_mem_wdata[63:0], b_mem_wdata[63:0], 64'hDEAD_BEEF_CAFE_0001);
      mem_req_ready = 1'b1;
      cyc();
      c2("t4 rf valid", a_mem_valid, b_mem_valid, 1);
      c2("t4 rf we", a_mem_we, b_mem_we, 0);
      c2("t4 rf addr", a_mem_addr, b_mem_addr, 32'h3100);
      cyc();
      mem_req_ready = 1'b0;
      c2("t5 wait valid", a_mem_valid, b_mem_valid, 0);

      // Reset while waiting for refill data abandons the transfer and empties the cache.
      rst = 1'b0;
      #1;
      c2("t5 rst stall", a_stall, b_stall, 0);
      c2("t5 rst resp", a_resp_valid, b_resp_valid, 0);
      c2("t5 rst mvalid", a_mem_valid, b_mem_valid, 0);
      c2("t5 rst mwe", a_mem_we, b_mem_we, 0);
      c2("t5 rst maddr", a_mem_addr, b_mem_addr, 0);
      cyc();
      rst = 1'b1;
      req(1'b0, 32'h2100, 32'h0);
      refill("t5 2100", 32'h2100, 32'h40, 32'h40);

      // Unsolicited refill data in IDLE must not disturb the arrays.
      cyc();
      cpu_req_valid = 1'b0;
      set_line(32'h99);
      mem_resp_valid = 1'b1;
      #1;
      c2("t6 idle resp", a_resp_valid, b_resp_valid, 0);
      c2("t6 idle stall", a_stall, b_stall, 0);
      cyc();
      cyc();
      mem_resp_valid = 1'b0;
      req(1'b0, 32'h2104, 32'h0);
      #1;
      c2("t6 hit resp", a_resp_valid, b_resp_valid, 1);
      c2("t6 rdata", a_rdata, b_rdata, 32'h41);
      c2("t6 mvalid", a_mem_valid, b_mem_valid, 0);
      cyc();

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
